// File: rtl/decoder_5to32_reg.sv
// ---------------------------------------------------------------------------
// decoder_5to32_reg
//
// Registered 5-to-32 one-hot decoder with output enable and tri-state
// outputs. Enable_In and Encoded_Value_In are captured on the rising edge of
// Clk_In. While the captured enable is 1, exactly one Data_k_Out is driven
// high (k = captured code) and the other 31 are driven low. While the captured
// enable is 0, every Data_k_Out floats, so several decoders can share one
// select bus.
//
// Ports:
//   Clk_In            in   1  system clock, rising edge active
//   Reset_In          in   1  synchronous reset, active-high
//   Enable_In         in   1  1 = drive outputs, 0 = tri-state all outputs
//   Encoded_Value_In  in   5  binary index (0..31) of the output to assert
//   Data_k_Out        out  1  one per k = 0..31, one-hot decoded bit k
//
// Outputs depend only on the registers, so input changes between edges never
// reach the outputs (latency is exactly one clock).
// ---------------------------------------------------------------------------
module decoder_5to32_reg (
  input  logic       Clk_In,
  input  logic       Reset_In,
  input  logic       Enable_In,
  input  logic [4:0] Encoded_Value_In,
  output logic       Data_0_Out,
  output logic       Data_1_Out,
  output logic       Data_2_Out,
  output logic       Data_3_Out,
  output logic       Data_4_Out,
  output logic       Data_5_Out,
  output logic       Data_6_Out,
  output logic       Data_7_Out,
  output logic       Data_8_Out,
  output logic       Data_9_Out,
  output logic       Data_10_Out,
  output logic       Data_11_Out,
  output logic       Data_12_Out,
  output logic       Data_13_Out,
  output logic       Data_14_Out,
  output logic       Data_15_Out,
  output logic       Data_16_Out,
  output logic       Data_17_Out,
  output logic       Data_18_Out,
  output logic       Data_19_Out,
  output logic       Data_20_Out,
  output logic       Data_21_Out,
  output logic       Data_22_Out,
  output logic       Data_23_Out,
  output logic       Data_24_Out,
  output logic       Data_25_Out,
  output logic       Data_26_Out,
  output logic       Data_27_Out,
  output logic       Data_28_Out,
  output logic       Data_29_Out,
  output logic       Data_30_Out,
  output logic       Data_31_Out
);

  logic        en_q;
  logic        en_d;
  logic [4:0]  code_q;
  logic [4:0]  code_d;
  logic [31:0] dec_s;

  // Next state: the code is captured even while disabled, so re-enabling
  // without a code change decodes the last captured code.
  always_comb begin
    en_d   = Enable_In;
    code_d = Encoded_Value_In;
  end

  // State register; reset wins over any input value at the same edge.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      en_q   <= 1'b0;
      code_q <= 5'd0;
    end else begin
      en_q   <= en_d;
      code_q <= code_d;
    end
  end

  // One-hot decode of the registered code; the 5-bit code covers all 32
  // positions, so there is no out-of-range case.
  always_comb begin
    dec_s = 32'h0000_0001 << code_q;
  end

  // Tri-state output drivers, one per decoded bit.
  assign Data_0_Out  = en_q ? dec_s[0]  : 1'bz;
  assign Data_1_Out  = en_q ? dec_s[1]  : 1'bz;
  assign Data_2_Out  = en_q ? dec_s[2]  : 1'bz;
  assign Data_3_Out  = en_q ? dec_s[3]  : 1'bz;
  assign Data_4_Out  = en_q ? dec_s[4]  : 1'bz;
  assign Data_5_Out  = en_q ? dec_s[5]  : 1'bz;
  assign Data_6_Out  = en_q ? dec_s[6]  : 1'bz;
  assign Data_7_Out  = en_q ? dec_s[7]  : 1'bz;
  assign Data_8_Out  = en_q ? dec_s[8]  : 1'bz;
  assign Data_9_Out  = en_q ? dec_s[9]  : 1'bz;
  assign Data_10_Out = en_q ? dec_s[10] : 1'bz;
  assign Data_11_Out = en_q ? dec_s[11] : 1'bz;
  assign Data_12_Out = en_q ? dec_s[12] : 1'bz;
  assign Data_13_Out = en_q ? dec_s[13] : 1'bz;
  assign Data_14_Out = en_q ? dec_s[14] : 1'bz;
  assign Data_15_Out = en_q ? dec_s[15] : 1'bz;
  assign Data_16_Out = en_q ? dec_s[16] : 1'bz;
  assign Data_17_Out = en_q ? dec_s[17] : 1'bz;
  assign Data_18_Out = en_q ? dec_s[18] : 1'bz;
  assign Data_19_Out = en_q ? dec_s[19] : 1'bz;
  assign Data_20_Out = en_q ? dec_s[20] : 1'bz;
  assign Data_21_Out = en_q ? dec_s[21] : 1'bz;
  assign Data_22_Out = en_q ? dec_s[22] : 1'bz;
  assign Data_23_Out = en_q ? dec_s[23] : 1'bz;
  assign Data_24_Out = en_q ? dec_s[24] : 1'bz;
  assign Data_25_Out = en_q ? dec_s[25] : 1'bz;
  assign Data_26_Out = en_q ? dec_s[26] : 1'bz;
  assign Data_27_Out = en_q ? dec_s[27] : 1'bz;
  assign Data_28_Out = en_q ? dec_s[28] : 1'bz;
  assign Data_29_Out = en_q ? dec_s[29] : 1'bz;
  assign Data_30_Out = en_q ? dec_s[30] : 1'bz;
  assign Data_31_Out = en_q ? dec_s[31] : 1'bz;

endmodule

// File: tb/tb_decoder_5to32_reg.sv
// ---------------------------------------------------------------------------
// tb_decoder_5to32_reg
//
// Two copies of the decoder share the same inputs. The outputs of one copy
// land on tri1 nets (float reads 1), the other on tri0 nets (float reads 0).
// A driven bit reads the same on both; a floating bit reads 1 / 0. Expected
// values are therefore pairs {hi_word, lo_word}:
//   enabled : hi = lo = 1 << code
//   disabled: hi = 32'hFFFF_FFFF, lo = 32'h0   (all outputs Z)
// ---------------------------------------------------------------------------
module tb_decoder_5to32_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [4:0] code;

  tri1 [31:0] hi_w;
  tri0 [31:0] lo_w;

  int n_pass;
  int n_total;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic [4:0]  code;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  decoder_5to32_reg u_dut_hi (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Encoded_Value_In(code),
    .Data_0_Out(hi_w[0]),   .Data_1_Out(hi_w[1]),   .Data_2_Out(hi_w[2]),   .Data_3_Out(hi_w[3]),
    .Data_4_Out(hi_w[4]),   .Data_5_Out(hi_w[5]),   .Data_6_Out(hi_w[6]),   .Data_7_Out(hi_w[7]),
    .Data_8_Out(hi_w[8]),   .Data_9_Out(hi_w[9]),   .Data_10_Out(hi_w[10]), .Data_11_Out(hi_w[11]),
    .Data_12_Out(hi_w[12]), .Data_13_Out(hi_w[13]), .Data_14_Out(hi_w[14]), .Data_15_Out(hi_w[15]),
    .Data_16_Out(hi_w[16]), .Data_17_Out(hi_w[17]), .Data_18_Out(hi_w[18]), .Data_19_Out(hi_w[19]),
    .Data_20_Out(hi_w[20]), .Data_21_Out(hi_w[21]), .Data_22_Out(hi_w[22]), .Data_23_Out(hi_w[23]),
    .Data_24_Out(hi_w[24]), .Data_25_Out(hi_w[25]), .Data_26_Out(hi_w[26]), .Data_27_Out(hi_w[27]),
    .Data_28_Out(hi_w[28]), .Data_29_Out(hi_w[29]), .Data_30_Out(hi_w[30]), .Data_31_Out(hi_w[31])
  );

  decoder_5to32_reg u_dut_lo (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Encoded_Value_In(code),
    .Data_0_Out(lo_w[0]),   .Data_1_Out(lo_w[1]),   .Data_2_Out(lo_w[2]),   .Data_3_Out(lo_w[3]),
    .Data_4_Out(lo_w[4]),   .Data_5_Out(lo_w[5]),   .Data_6_Out(lo_w[6]),   .Data_7_Out(lo_w[7]),
    .Data_8_Out(lo_w[8]),   .Data_9_Out(lo_w[9]),   .Data_10_Out(lo_w[10]), .Data_11_Out(lo_w[11]),
    .Data_12_Out(lo_w[12]), .Data_13_Out(lo_w[13]), .Data_14_Out(lo_w[14]), .Data_15_Out(lo_w[15]),
    .Data_16_Out(lo_w[16]), .Data_17_Out(lo_w[17]), .Data_18_Out(lo_w[18]), .Data_19_Out(lo_w[19]),
    .Data_20_Out(lo_w[20]), .Data_21_Out(lo_w[21]), .Data_22_Out(lo_w[22]), .Data_23_Out(lo_w[23]),
    .Data_24_Out(lo_w[24]), .Data_25_Out(lo_w[25]), .Data_26_Out(lo_w[26]), .Data_27_Out(lo_w[27]),
    .Data_28_Out(lo_w[28]), .Data_29_Out(lo_w[29]), .Data_30_Out(lo_w[30]), .Data_31_Out(lo_w[31])
  );

  // Reference model: expected tri1-side word.
  function automatic logic [31:0] model_hi(input logic e, input logic [4:0] c);
    logic [31:0] one;
    one = 32'h0000_0001;
    return e ? (one << c) : 32'hFFFF_FFFF;
  endfunction

  // Reference model: expected tri0-side word.
  function automatic logic [31:0] model_lo(input logic e, input logic [4:0] c);
    logic [31:0] one;
    one = 32'h0000_0001;
    return e ? (one << c) : 32'h0000_0000;
  endfunction

  task automatic check(input string nm, input logic [31:0] eh, input logic [31:0] el);
    n_total++;
    if ({hi_w, lo_w} === {eh, el}) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h", nm, hi_w, lo_w, eh, el);
    end
  endtask

  // Drive inputs (called #1 after an edge), push the expectation, advance one
  // edge, then pop and compare.
  task automatic step(input string nm, input logic r, input logic e, input logic [4:0] c,
                      input logic [31:0] eh, input logic [31:0] el);
    exp_t x;
    rst  = r;
    en   = e;
    code = c;
    sb.push_back('{nm, eh, el});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check(x.name, x.hi, x.lo);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] rc;
    logic       re;
    n_pass  = 0;
    n_total = 0;
    rst  = 1'b1;
    en   = 1'b1;
    code = 5'd5;

    // Directed vectors with literal expectations.
    vecs.push_back('{"reset_edge1",   1'b1, 1'b1, 5'd5,  32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{"reset_edge2",   1'b1, 1'b1, 5'd5,  32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{"reset_release", 1'b0, 1'b1, 5'd5,  32'h0000_0020, 32'h0000_0020});
    vecs.push_back('{"disabled_19",   1'b0, 1'b0, 5'd19, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{"reenable_19",   1'b0, 1'b1, 5'd19, 32'h0008_0000, 32'h0008_0000});
    vecs.push_back('{"code_0",        1'b0, 1'b1, 5'd0,  32'h0000_0001, 32'h0000_0001});
    vecs.push_back('{"code_31",       1'b0, 1'b1, 5'd31, 32'h8000_0000, 32'h8000_0000});
    vecs.push_back('{"reset_prio",    1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{"after_reset",   1'b0, 1'b1, 5'd15, 32'h0000_8000, 32'h0000_8000});

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      step(vecs[i].name, vecs[i].rst, vecs[i].en, vecs[i].code, vecs[i].hi, vecs[i].lo);
    end

    // Exhaustive sweep of all codes while enabled.
    for (int k = 0; k < 32; k++) begin
      rc = 5'(k);
      step($sformatf("sweep_%0d", k), 1'b0, 1'b1, rc, model_hi(1'b1, rc), model_lo(1'b1, rc));
    end

    // Capture while disabled, then re-enable with an unchanged code.
    step("dis_capture_12", 1'b0, 1'b0, 5'd12, 32'hFFFF_FFFF, 32'h0000_0000);
    rst = 1'b0;
    en  = 1'b1;
    @(posedge clk);
    #1;
    check("reenable_keeps_12", 32'h0000_1000, 32'h0000_1000);

    // Latency/hold: code change mid-cycle must not reach outputs before the edge.
    step("hold_code3", 1'b0, 1'b1, 5'd3, 32'h0000_0008, 32'h0000_0008);
    #2;
    code = 5'd9;
    #1;
    check("hold_mid_cycle", 32'h0000_0008, 32'h0000_0008);
    @(posedge clk);
    #1;
    check("hold_after_edge", 32'h0000_0200, 32'h0000_0200);

    // Enable toggling on a fixed code.
    step("toggle_en1", 1'b0, 1'b1, 5'd7, 32'h0000_0080, 32'h0000_0080);
    step("toggle_en0", 1'b0, 1'b0, 5'd7, 32'hFFFF_FFFF, 32'h0000_0000);
    step("toggle_en1b", 1'b0, 1'b1, 5'd7, 32'h0000_0080, 32'h0000_0080);

    // Random enable/code against the model.
    for (int r = 0; r < 20; r++) begin
      re = 1'($urandom_range(1, 0));
      rc = 5'($urandom_range(31, 0));
      step($sformatf("random_%0d", r), 1'b0, re, rc, model_hi(re, rc), model_lo(re, rc));
    end

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
